// File: rtl/thread_sched.sv
// Thread scheduler for the barrel pipeline front end.
// Keeps a per-thread active mask (spawn sets a bit, halt clears it). Each
// cycle it picks the thread whose PC is fetched next, either on fixed
// barrel slots or by skipping inactive threads.
module thread_sched #(
  parameter int                     NUM_THREADS   = 8,
  parameter logic [NUM_THREADS-1:0] RESET_MASK    = NUM_THREADS'(1),
  parameter bit                     STRICT_BARREL = 1'b1,
  localparam int                    BITS_THREADS  = $clog2(NUM_THREADS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    start_valid,
  input  logic [BITS_THREADS-1:0] start_tid,
  input  logic                    halt_valid,
  input  logic [BITS_THREADS-1:0] halt_tid,
  output logic [BITS_THREADS-1:0] tid,
  output logic                    tid_valid,
  output logic [NUM_THREADS-1:0]  active_mask,
  output logic                    all_idle
);

  logic [NUM_THREADS-1:0]  next_mask;
  logic [BITS_THREADS-1:0] next_tid;
  logic                    next_valid;
  logic [BITS_THREADS-1:0] cand;
  logic                    found;

  // Mask update: halt clears first, then start sets, so a start wins on a
  // same-thread collision.
  always_comb begin
    // NOTE: every always_comb output gets a default up front so no path
    // leaves it unassigned and no latch is inferred.
    next_mask = active_mask;
    if (halt_valid) next_mask[halt_tid] = 1'b0;
    if (start_valid) next_mask[start_tid] = 1'b1;
  end

  // Next issue slot, chosen from the registered mask only (one cycle of
  // latency for start/halt).
  always_comb begin
    next_tid   = tid;
    next_valid = 1'b0;
    cand       = '0;
    found      = 1'b0;
    if (STRICT_BARREL) begin
      next_tid   = tid + BITS_THREADS'(1);
      next_valid = active_mask[next_tid];
    end else begin
      // Circular search from tid+1 around to tid itself; the final step
      // wraps back onto tid so a lone active thread reissues every cycle.
      for (int i = 1; i <= NUM_THREADS; i++) begin
        cand = tid + BITS_THREADS'(i);
        if (!found && active_mask[cand]) begin
          found    = 1'b1;
          next_tid = cand;
        end
      end
      next_valid = found;
    end
  end

  // State registers: mask always advances, issue slot holds under stall.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!rst) begin
      active_mask <= RESET_MASK;
      tid         <= '1;
      tid_valid   <= 1'b0;
    end else begin
      active_mask <= next_mask;
      if (!stall) begin
        tid       <= next_tid;
        tid_valid <= next_valid;
      end
    end
  end

  // Idle flag reflects the registered mask, not the pending update.
  assign all_idle = (active_mask == '0);

endmodule
